// File: rtl/sprite_eval.sv
// Per-scanline sprite evaluation: clears secondary OAM, then copies up to SEC_SLOTS
// primary OAM entries that cover the next scanline, flagging sprite 0 and overflow.
module sprite_eval #(
  parameter int OAM_ENTRIES = 64,
  parameter int SEC_SLOTS   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       eval_start,
  input  logic [7:0] next_line_y,
  input  logic       sprite_16,
  input  logic       overflow_clr,
  output logic [7:0] oam_addr,
  input  logic [7:0] oam_data,
  output logic       sec_we,
  output logic [4:0] sec_addr,
  output logic [7:0] sec_data,
  output logic       eval_busy,
  output logic       eval_done,
  output logic [3:0] sec_count,
  output logic       sprite0_in_line,
  output logic       sprite_overflow
);

  localparam int NW  = $clog2(OAM_ENTRIES);
  localparam int SW  = $clog2(SEC_SLOTS);
  localparam int CW  = SW + 2;
  localparam int SLW = $clog2(SEC_SLOTS + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CLEAR     = 4'd1;
  localparam logic [3:0] S_READ_Y    = 4'd2;
  localparam logic [3:0] S_CHECK_Y   = 4'd3;
  localparam logic [3:0] S_COPY1     = 4'd4;
  localparam logic [3:0] S_COPY2     = 4'd5;
  localparam logic [3:0] S_COPY3     = 4'd6;
  localparam logic [3:0] S_OVF_READ  = 4'd7;
  localparam logic [3:0] S_OVF_CHECK = 4'd8;
  localparam logic [3:0] S_DONE      = 4'd9;

  logic [3:0]     state;
  logic [7:0]     line_q;
  logic           tall_q;
  logic [NW-1:0]  n;
  logic [SLW-1:0] slot;
  logic [CW-1:0]  clr_idx;

  logic [8:0]     diff;
  logic           in_range;
  logic           last_n;
  logic [SLW-1:0] slot_after;
  logic [3:0]     adv_state;
  logic [SW-1:0]  slot_idx;

  // The "next sprite" step is folded into the last cycle of each sprite, so a
  // rejected sprite costs READ_Y + CHECK_Y only.
  always_comb begin
    diff       = {1'b0, line_q} - {1'b0, oam_data};
    in_range   = !diff[8] && (diff[7:0] < (tall_q ? 8'd16 : 8'd8)) && (oam_data < 8'hEF);
    last_n     = (n == NW'(OAM_ENTRIES - 1));
    slot_after = (state == S_COPY3) ? slot + SLW'(1) : slot;
    slot_idx   = slot[SW-1:0];
    if (last_n)
      adv_state = S_DONE;
    else if (slot_after == SLW'(SEC_SLOTS))
      adv_state = S_OVF_READ;
    else
      adv_state = S_READ_Y;
  end

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned; otherwise a latch would be inferred.
  always_comb begin
    oam_addr = 8'd0;
    sec_we   = 1'b0;
    sec_addr = 5'd0;
    sec_data = 8'hFF;
    case (state)
      S_CLEAR: begin
        sec_we   = 1'b1;
        sec_addr = 5'(clr_idx);
      end
      S_READ_Y, S_OVF_READ: oam_addr = 8'({n, 2'b00});
      S_CHECK_Y: begin
        oam_addr = 8'({n, 2'b01});
        if (in_range) begin
          sec_we   = 1'b1;
          sec_addr = 5'({slot_idx, 2'b00});
          sec_data = oam_data;
        end
      end
      S_COPY1: begin
        oam_addr = 8'({n, 2'b10});
        sec_we   = 1'b1;
        sec_addr = 5'({slot_idx, 2'b01});
        sec_data = oam_data;
      end
      S_COPY2: begin
        oam_addr = 8'({n, 2'b11});
        sec_we   = 1'b1;
        sec_addr = 5'({slot_idx, 2'b10});
        sec_data = oam_data;
      end
      S_COPY3: begin
        sec_we   = 1'b1;
        sec_addr = 5'({slot_idx, 2'b11});
        sec_data = oam_data;
      end
      default: ;
    endcase
  end

  assign eval_busy = (state != S_IDLE) && (state != S_DONE);
  assign eval_done = (state == S_DONE);
  assign sec_count = 4'(slot);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      line_q          <= 8'd0;
      tall_q          <= 1'b0;
      n               <= '0;
      slot            <= '0;
      clr_idx         <= '0;
      sprite0_in_line <= 1'b0;
      sprite_overflow <= 1'b0;
    end else begin
      // A set later in this block overrides this clear in the same cycle.
      if (overflow_clr) sprite_overflow <= 1'b0;

      if (eval_start) begin
        state           <= S_CLEAR;
        line_q          <= next_line_y;
        tall_q          <= sprite_16;
        n               <= '0;
        slot            <= '0;
        clr_idx         <= '0;
        sprite0_in_line <= 1'b0;
      end else begin
        case (state)
          S_CLEAR: begin
            clr_idx <= clr_idx + CW'(1);
            if (clr_idx == CW'(4 * SEC_SLOTS - 1)) state <= S_READ_Y;
          end
          S_READ_Y: state <= S_CHECK_Y;
          S_CHECK_Y: begin
            if (in_range) begin
              state <= S_COPY1;
              if (n == '0) sprite0_in_line <= 1'b1;
            end else begin
              n     <= n + NW'(1);
              state <= adv_state;
            end
          end
          S_COPY1: state <= S_COPY2;
          S_COPY2: state <= S_COPY3;
          S_COPY3: begin
            slot  <= slot_after;
            n     <= n + NW'(1);
            state <= adv_state;
          end
          S_OVF_READ: state <= S_OVF_CHECK;
          S_OVF_CHECK: begin
            if (in_range) begin
              sprite_overflow <= 1'b1;
              state           <= S_DONE;
            end else if (last_n) begin
              state <= S_DONE;
            end else begin
              n     <= n + NW'(1);
              state <= S_OVF_READ;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
